// File: rtl/voice_pkg.sv
// Shared types for the polyphonic voice allocator: FSM states, selection classes
// and the default note/stamp/voice-index widths.
package voice_pkg;

  localparam int NOTE_BITS_DEF  = 7;
  localparam int STAMP_BITS_DEF = 8;
  localparam int MAX_VOICES     = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GAP,
    ASSIGN
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MATCH,
    SEL_FREE,
    SEL_RELEASING,
    SEL_GATED
  } sel_class_t;

  typedef logic [NOTE_BITS_DEF-1:0]      note_t;
  typedef logic [STAMP_BITS_DEF-1:0]     stamp_t;
  typedef logic [$clog2(MAX_VOICES)-1:0] voice_idx_t;

endpackage

// File: rtl/voice_select.sv
// Combinational target chooser: same-note gated voice, else first free voice,
// else oldest releasing voice, else oldest gated voice (age = alloc_cnt - stamp).
module voice_select
  import voice_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int NOTE_BITS  = NOTE_BITS_DEF,
  parameter int STAMP_BITS = STAMP_BITS_DEF
) (
  input  logic [VOICES-1:0]                 gate,
  input  logic [VOICES-1:0][NOTE_BITS-1:0]  note,
  input  logic [VOICES-1:0]                 voice_active,
  input  logic [VOICES-1:0][STAMP_BITS-1:0] stamp,
  input  logic [STAMP_BITS-1:0]             alloc_cnt,
  input  logic [NOTE_BITS-1:0]              ev_note,
  output voice_idx_t                        target,
  output sel_class_t                        cls
);

  logic                  match_hit, free_hit, rel_hit, gated_hit;
  voice_idx_t            match_idx, free_idx, rel_idx, gated_idx;
  logic [STAMP_BITS-1:0] rel_age, gated_age, age;

  always_comb begin
    // NOTE: every variable written here gets a default before any branch,
    // otherwise paths that skip an assignment would infer latches.
    match_hit = 1'b0;  match_idx = '0;
    free_hit  = 1'b0;  free_idx  = '0;
    rel_hit   = 1'b0;  rel_idx   = '0;  rel_age   = '0;
    gated_hit = 1'b0;  gated_idx = '0;  gated_age = '0;
    age       = '0;
    target    = '0;
    cls       = SEL_NONE;

    // Ascending scan with strict '>' keeps the lowest index on equal ages.
    for (int i = 0; i < VOICES; i++) begin
      age = alloc_cnt - stamp[i];
      if (gate[i] && note[i] == ev_note && !match_hit) begin
        match_hit = 1'b1;
        match_idx = voice_idx_t'(i);
      end
      if (!gate[i] && !voice_active[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = voice_idx_t'(i);
      end
      if (!gate[i] && voice_active[i] && (!rel_hit || age > rel_age)) begin
        rel_hit = 1'b1;
        rel_idx = voice_idx_t'(i);
        rel_age = age;
      end
      if (gate[i] && (!gated_hit || age > gated_age)) begin
        gated_hit = 1'b1;
        gated_idx = voice_idx_t'(i);
        gated_age = age;
      end
    end

    if (match_hit) begin
      cls = SEL_MATCH;     target = match_idx;
    end else if (free_hit) begin
      cls = SEL_FREE;      target = free_idx;
    end else if (rel_hit) begin
      cls = SEL_RELEASING; target = rel_idx;
    end else if (gated_hit) begin
      cls = SEL_GATED;     target = gated_idx;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: note events in, per-voice gate/note out.
// Define VOICE_ALLOC_STEAL_EN to steal the oldest voice instead of dropping note-ons.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int VOICES     = 4,
  parameter int NOTE_BITS  = NOTE_BITS_DEF,
  parameter int STAMP_BITS = STAMP_BITS_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_on,
  input  logic [NOTE_BITS-1:0]          ev_note,
  input  logic [VOICES-1:0]             voice_active,
  output logic [VOICES-1:0]             gate,
  output logic [VOICES*NOTE_BITS-1:0]   note,
  output logic                          stolen,
  output logic                          dropped
);

`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL_EN = 1'b1;
`else
  localparam bit STEAL_EN = 1'b0;
`endif

  state_t                          state, state_next;
  logic                            on_q;
  logic [NOTE_BITS-1:0]            ev_note_q;
  voice_idx_t                      target_q;
  logic [VOICES-1:0]               gate_q;
  logic [VOICES-1:0][NOTE_BITS-1:0]  note_q;
  logic [VOICES-1:0][STAMP_BITS-1:0] stamp_q;
  logic [STAMP_BITS-1:0]           alloc_cnt;
  logic                            stolen_q, dropped_q;

  voice_idx_t sel_idx;
  sel_class_t sel_cls;

  logic       latch_ev, off_clear, commit, gap_start, stolen_set, dropped_set;
  voice_idx_t commit_idx;

  voice_select #(
    .VOICES     (VOICES),
    .NOTE_BITS  (NOTE_BITS),
    .STAMP_BITS (STAMP_BITS)
  ) u_select (
    .gate         (gate_q),
    .note         (note_q),
    .voice_active (voice_active),
    .stamp        (stamp_q),
    .alloc_cnt    (alloc_cnt),
    .ev_note      (ev_note_q),
    .target       (sel_idx),
    .cls          (sel_cls)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // GAP's outgoing edge performs the assignment, so a retrigger or gated steal
  // holds ev_ready low for exactly two cycles; ASSIGN is never resident.
  always_comb begin
    state_next  = state;
    latch_ev    = 1'b0;
    off_clear   = 1'b0;
    commit      = 1'b0;
    commit_idx  = sel_idx;
    gap_start   = 1'b0;
    stolen_set  = 1'b0;
    dropped_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev_valid) begin
          latch_ev   = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        state_next = IDLE;
        if (!on_q) begin
          off_clear = 1'b1;
        end else begin
          unique case (sel_cls)
            SEL_MATCH: begin
              gap_start  = 1'b1;
              state_next = GAP;
            end
            SEL_FREE: commit = 1'b1;
            SEL_RELEASING: begin
              if (STEAL_EN) begin
                commit     = 1'b1;
                stolen_set = 1'b1;
              end else begin
                dropped_set = 1'b1;
              end
            end
            SEL_GATED: begin
              if (STEAL_EN) begin
                gap_start  = 1'b1;
                stolen_set = 1'b1;
                state_next = GAP;
              end else begin
                dropped_set = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      GAP: begin
        commit     = 1'b1;
        commit_idx = target_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the per-voice note and stamp arrays are reset together with the gates
  // because their reset values are visible on the outputs and feed the age compare.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      on_q      <= 1'b0;
      ev_note_q <= '0;
      target_q  <= '0;
      gate_q    <= '0;
      note_q    <= '0;
      stamp_q   <= '0;
      alloc_cnt <= '0;
      stolen_q  <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      stolen_q  <= stolen_set;
      dropped_q <= dropped_set;
      if (latch_ev) begin
        on_q      <= ev_on;
        ev_note_q <= ev_note;
      end
      if (gap_start) target_q <= sel_idx;
      if (commit)    alloc_cnt <= alloc_cnt + 1'b1;
      for (int i = 0; i < VOICES; i++) begin
        if (off_clear && gate_q[i] && note_q[i] == ev_note_q) gate_q[i] <= 1'b0;
        if (gap_start && sel_idx == voice_idx_t'(i))          gate_q[i] <= 1'b0;
        if (commit && commit_idx == voice_idx_t'(i)) begin
          gate_q[i]  <= 1'b1;
          note_q[i]  <= ev_note_q;
          stamp_q[i] <= alloc_cnt;
        end
      end
    end
  end

  assign ev_ready = (state == IDLE);
  assign gate     = gate_q;
  assign note     = note_q;
  assign stolen   = stolen_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized and directed bench for voice_allocator against a voice-table model.
// Honours VOICE_ALLOC_STEAL_EN the same way as the design.
module tb_voice_allocator;

  localparam int V  = 4;
  localparam int NB = 7;

`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  localparam int C_NONE  = 0;
  localparam int C_MATCH = 1;
  localparam int C_FREE  = 2;
  localparam int C_REL   = 3;
  localparam int C_GATED = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_on = 1'b0;
  logic [NB-1:0]   ev_note = '0;
  logic [V-1:0]    voice_active = '0;
  logic [V-1:0]    gate;
  logic [V*NB-1:0] note;
  logic            stolen;
  logic            dropped;

  int vectors = 0;
  int miscompares = 0;

  // Reference voice table: allocation stamps kept as counts modulo 256.
  bit m_gate [V];
  int m_note [V];
  int m_stamp[V];
  int m_cnt;

  voice_allocator #(.VOICES(V), .NOTE_BITS(NB), .STAMP_BITS(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_note      (ev_note),
    .voice_active (voice_active),
    .gate         (gate),
    .note         (note),
    .stolen       (stolen),
    .dropped      (dropped)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_gate();
    logic [31:0] v = '0;
    for (int i = 0; i < V; i++) v[i] = m_gate[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_note();
    logic [31:0] v = '0;
    for (int i = 0; i < V; i++) v[i*NB +: NB] = NB'(m_note[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < V; i++) begin
      m_gate[i] = 1'b0; m_note[i] = 0; m_stamp[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_commit(input int i, input int n);
    m_gate[i]  = 1'b1;
    m_note[i]  = n;
    m_stamp[i] = m_cnt;
    m_cnt      = (m_cnt + 1) % 256;
  endtask

  task automatic pick(input int n, input logic [V-1:0] act, output int cls, output int idx);
    int best_age;
    cls = C_NONE; idx = 0;
    for (int i = 0; i < V && cls == C_NONE; i++)
      if (m_gate[i] && m_note[i] == n) begin cls = C_MATCH; idx = i; end
    for (int i = 0; i < V && cls == C_NONE; i++)
      if (!m_gate[i] && !act[i]) begin cls = C_FREE; idx = i; end
    if (cls == C_NONE) begin
      best_age = -1;
      for (int i = 0; i < V; i++)
        if (!m_gate[i] && act[i] && ((m_cnt - m_stamp[i] + 256) % 256) > best_age) begin
          best_age = (m_cnt - m_stamp[i] + 256) % 256; idx = i; cls = C_REL;
        end
    end
    if (cls == C_NONE) begin
      best_age = -1;
      for (int i = 0; i < V; i++)
        if (m_gate[i] && ((m_cnt - m_stamp[i] + 256) % 256) > best_age) begin
          best_age = (m_cnt - m_stamp[i] + 256) % 256; idx = i; cls = C_GATED;
        end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    ev_valid = 1'b0;
    @(negedge clock);
    check("rst_gate",    32'(gate),    32'h0);
    check("rst_note",    32'(note),    32'h0);
    check("rst_ready",   32'(ev_ready), 32'h1);
    check("rst_stolen",  32'(stolen),  32'h0);
    check("rst_dropped", 32'(dropped), 32'h0);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
  endtask

  // Called at a negedge; returns at a negedge with the event fully retired.
  task automatic do_event(input bit on, input int n, input logic [V-1:0] act);
    int cls, idx, w;
    bit gap, e_st, e_dr;
    w = 0;
    while (!ev_ready && w < 8) begin
      @(negedge clock);
      w++;
    end
    check("ready_idle", 32'(ev_ready), 32'h1);
    voice_active = act;
    ev_valid = 1'b1; ev_on = on; ev_note = NB'(n);
    cls = C_NONE; idx = 0; gap = 1'b0; e_st = 1'b0; e_dr = 1'b0;
    if (on) pick(n, act, cls, idx);
    @(posedge clock);
    @(negedge clock);
    ev_valid = 1'b0;
    check("ready_scan", 32'(ev_ready), 32'h0);
    if (!on) begin
      for (int i = 0; i < V; i++)
        if (m_gate[i] && m_note[i] == n) m_gate[i] = 1'b0;
    end else begin
      case (cls)
        C_MATCH: begin gap = 1'b1; m_gate[idx] = 1'b0; end
        C_FREE:  model_commit(idx, n);
        C_REL: begin
          if (STEAL) begin model_commit(idx, n); e_st = 1'b1; end
          else e_dr = 1'b1;
        end
        C_GATED: begin
          if (STEAL) begin gap = 1'b1; m_gate[idx] = 1'b0; e_st = 1'b1; end
          else e_dr = 1'b1;
        end
        default: ;
      endcase
    end
    @(posedge clock);
    @(negedge clock);
    check("e1_gate",    32'(gate),     exp_gate());
    check("e1_note",    32'(note),     exp_note());
    check("e1_stolen",  32'(stolen),   32'(e_st));
    check("e1_dropped", 32'(dropped),  32'(e_dr));
    check("e1_ready",   32'(ev_ready), 32'(!gap));
    if (gap) begin
      model_commit(idx, n);
      @(posedge clock);
      @(negedge clock);
      check("e2_gate",   32'(gate),     exp_gate());
      check("e2_note",   32'(note),     exp_note());
      check("e2_stolen", 32'(stolen),   32'h0);
      check("e2_ready",  32'(ev_ready), 32'h1);
    end
  endtask

  initial begin
    logic [V-1:0] act;
    model_reset();
    do_reset();

    // First note lands on voice 0.
    do_event(1'b1, 60, 4'h0);
    check("t1_gate",  32'(gate),      32'h1);
    check("t1_note0", 32'(note[6:0]), 32'd60);

    // Fill, then a fifth note steals (or is dropped at) the oldest voice.
    do_event(1'b1, 62, 4'h1);
    do_event(1'b1, 64, 4'h3);
    do_event(1'b1, 65, 4'h7);
    do_event(1'b1, 67, 4'hF);
    check("t2_gate",  32'(gate),      32'hF);
    check("t2_note0", 32'(note[6:0]), STEAL ? 32'd67 : 32'd60);

    // Releasing voice 1 is reused directly, no gap.
    do_event(1'b0, 62, 4'hF);
    check("t3_gate_off", 32'(gate), 32'hD);
    do_event(1'b1, 70, 4'hF);
    check("t3_note1", 32'(note[13:7]), STEAL ? 32'd70 : 32'd62);

    // Same-note retrigger and note-off handling.
    do_reset();
    do_event(1'b1, 60, 4'h0);
    do_event(1'b1, 60, 4'h1);
    check("t4_gate", 32'(gate), 32'h1);
    do_event(1'b0, 60, 4'h1);
    check("t4_off", 32'(gate), 32'h0);
    do_event(1'b0, 61, 4'h1);
    check("t4_nomatch", 32'(gate), 32'h0);

    // Push alloc_cnt past a wrap so the filled stamps straddle 255 -> 0.
    do_reset();
    for (int k = 0; k < 510; k++) begin
      do_event(1'b1, 10, 4'h0);
      do_event(1'b0, 10, 4'h0);
    end
    for (int k = 0; k < V; k++) do_event(1'b1, 20 + k, exp_gate()[V-1:0]);
    do_event(1'b1, 30, 4'hF);
    check("t5_note0", 32'(note[6:0]), STEAL ? 32'd30 : 32'd20);

    // Random traffic over a narrow note range for frequent matches.
    do_reset();
    for (int k = 0; k < 250; k++) begin
      act = V'($urandom) | exp_gate()[V-1:0];
      do_event(($urandom_range(0, 9) < 6), 60 + $urandom_range(0, 7), act);
    end

    // Reset while a retrigger sits in GAP.
    do_reset();
    do_event(1'b1, 50, 4'h0);
    voice_active = 4'h1;
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = NB'(50);
    @(posedge clock);
    @(negedge clock);
    ev_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("gap_gate", 32'(gate), 32'h0);
    #2 reset = 1'b1;
    #1;
    check("gaprst_gate",  32'(gate),     32'h0);
    check("gaprst_note",  32'(note),     32'h0);
    check("gaprst_ready", 32'(ev_ready), 32'h1);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("post_ready", 32'(ev_ready), 32'h1);
    check("post_gate",  32'(gate),     32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
